// File: rtl/uart_pkg.sv
// Shared UART types and defaults for the receiver and transmitter.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int UART_DATA_W     = 8;
  localparam int UART_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
`timescale 1ns/1ps
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] ff_q;
  logic [1:0] ff_d;

  always_comb begin
    ff_d = {ff_q[0], d};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff_q <= {2{RST_VAL}};
    end else begin
      ff_q <= ff_d;
    end
  end

  assign q = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// Oversampled UART receiver with valid/ready output and error flags.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic              rx_in,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              framing_err,
  output logic              parity_err,
  output logic              overrun_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DATA_W - 1);

  logic rx_s;

  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              fe_q, fe_d;
  logic              ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  localparam logic PODD = 1'(PARITY_ODD);
  logic              pmis_q, pmis_d;
  logic              pe_q, pe_d;
`endif

  uart_sync2 #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx_in),
    .q  (rx_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = fe_q;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    pmis_d  = pmis_q;
    pe_d    = pe_q;
`endif
    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
    if (sample_tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == HALF) begin
            if (!rx_s) begin
              state_d = DATA;
              cnt_d   = '0;
              idx_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == FULL) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[DATA_W-1:1]};
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == FULL) begin
            cnt_d   = '0;
            pmis_d  = rx_s ^ (^shift_q) ^ PODD;
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt_q == FULL) begin
            // A pending frame not taken this cycle is lost.
            ovr_d   = valid_q && !rx_ready;
            data_d  = shift_q;
            fe_d    = ~rx_s;
`ifdef UART_RX_PARITY_EN
            pe_d    = pmis_q;
`endif
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pmis_q  <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      pmis_q  <= pmis_d;
      pe_q    <= pe_d;
`endif
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign framing_err = fe_q;
  assign overrun_err = ovr_q;
  assign busy        = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err  = pe_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule
